// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: a single full-adder slice walks the operands LSB first,
// producing one result bit per clock, with NZCV-style flags captured on completion.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic             busy,
    output logic             done
);

    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             v_q;
    logic             z_q;
    logic             n_q;
    logic             busy_q;
    logic             done_q;

    logic             a_bit;
    logic             b_bit;
    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] s_d;
    logic             last_bit;

    // Full-adder slice operating on the bit selected by the counter.
    always_comb begin
        a_bit          = a_q[cnt_q];
        b_bit          = b_q[cnt_q];
        sum_bit        = a_bit ^ b_bit ^ carry_q;
        carry_d        = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
        s_d            = s_q;
        s_d[cnt_q]     = sum_bit;
        last_bit       = (cnt_q == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                        a_q     <= A;
                        b_q     <= B ^ {WIDTH{mode}};
                        carry_q <= mode;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= carry_d;
                    if (last_bit) begin
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        cout_q  <= carry_d;
                        v_q     <= carry_q ^ carry_d;
                        z_q     <= (s_d == '0);
                        n_q     <= sum_bit;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign Z    = z_q;
    assign N    = n_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request new operation; sampled on rising clk edge.
REQ-005 SHALL have port mode  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port A  input  WIDTH  first operand; sampled with start.
REQ-007 SHALL have port B  input  WIDTH  second operand; sampled with start.
REQ-008 SHALL have port S  output  WIDTH  result, two's-complement wrap.
REQ-009 SHALL have port Cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-010 SHALL have port V  output  1  signed overflow.
REQ-011 SHALL have port Z  output  1  S equals zero.
REQ-012 SHALL have port N  output  1  S[WIDTH-1].
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse; S/flags valid.

Function
REQ-015 SHALL compute with a single 1-bit full-adder slice, one bit per cycle, LSB first.
REQ-016 Arithmetic SHALL be A + (B XOR {WIDTH{mode}}) + mode; initial carry = mode.
REQ-017 FSM SHALL have states IDLE, RUN, DONE.
REQ-018 IDLE/DONE with start=1 at edge t0: latch A, B^mask, carry=mode; bit counter=0; go RUN.
REQ-019 IDLE/DONE with start=0: DONE goes to IDLE; IDLE holds.
REQ-020 RUN SHALL process bit i at edge t0+1+i, i = 0..WIDTH-1.
REQ-021 Counter SHALL be $clog2(WIDTH) bits wide (minimum 1) and SHALL NOT wrap inside an operation.
REQ-022 At edge t0+WIDTH, after bit WIDTH-1 is processed, state SHALL be DONE.
REQ-023 busy SHALL be 1 exactly while state is RUN, i.e. cycles after edges t0..t0+WIDTH-1.
REQ-024 done SHALL be 1 exactly while state is DONE: a single cycle unless start re-launches.
REQ-025 Latency SHALL be start edge to done high = WIDTH edges.
REQ-026 S SHALL change only bit-wise during RUN; final value at DONE.
REQ-027 Cout, V, Z and N SHALL update only at entry to DONE.
REQ-028 Cout, V, Z, N, S SHALL hold from DONE until the next accepted start.
REQ-029 V SHALL equal (carry into MSB) XOR (carry out of MSB).
REQ-030 start while RUN SHALL be ignored: no relatch, no restart.
REQ-031 start in DONE SHALL be accepted: done=1 this cycle, busy=1 next cycle.
REQ-032 mode, A and B changes while busy SHALL have no effect on the result.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, S=0, Cout=V=N=0, Z=1, busy=0, done=0, counter=0, operand registers=0.
REQ-034 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-035 start SHALL be ignored while rst=1; first accepted start is at the first edge with rst=0.

Verification (WIDTH=8)
REQ-036 Add 100+27 -> done 8 edges after start; S=0x7F, Cout=0, V=0, Z=0, N=0.
REQ-037 Add 0x7F+0x01 -> S=0x80, V=1, N=1, Cout=0; add 0xFF+0x01 -> S=0x00, Cout=1, Z=1, V=0.
REQ-038 Sub 5-5 -> S=0x00, Z=1, Cout=1; sub 3-5 -> S=0xFE, Cout=0, N=1, V=0; sub 0x80-0x01 -> S=0x7F, V=1.
REQ-039 Second start plus changed A/B at 3 edges into RUN -> ignored; first result unchanged; done exactly once.
REQ-040 Back-to-back: start held high through DONE -> second op launches; done pulses are 9 cycles apart.
REQ-041 rst pulse at 4 edges into RUN -> outputs at reset values at once; no done; next start computes correctly.
